// File: rtl/ddr_pkg.sv
// Shared types and sizing for the DDR responder and its backing array.
package ddr_pkg;

    localparam int WORD_W      = 64;
    localparam int BURST_BEATS = 8;
    localparam int LINE_W      = WORD_W * BURST_BEATS;
    localparam int BEAT_W      = $clog2(BURST_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } ddr_state_e;

    // Wait counter counts LATENCY-1 down to 0; keep at least one bit for LATENCY=1.
    function automatic int wait_cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/ddr_mem_array.sv
// Single-port DEPTH x 64 word array: registered read, bit-masked write.
module ddr_mem_array
  import ddr_pkg::*;
#(
  parameter int    ADDR_WIDTH = 19,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write_enable,
  input  logic [WORD_W-1:0]     write_mask,
  input  logic [WORD_W-1:0]     write_data,
  output logic [WORD_W-1:0]     read_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are never cleared by reset.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[addr] <= (mem[addr] & ~write_mask) | (write_data & write_mask);
    end
    read_data <= mem[addr];
  end

endmodule

// File: rtl/ddr_responder.sv
// DDR request responder: one op in flight, fixed wait latency, single word
// load/store or 8-beat instruction burst read out of ddr_mem_array.
module ddr_responder
    import ddr_pkg::*;
#(
    parameter int    ADDR_WIDTH = 19,
    parameter int    LATENCY    = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ddr_chip_enable,
    input  logic [ADDR_WIDTH-1:0] ddr_index,
    input  logic                  ddr_write_enable,
    input  logic                  ddr_burst_mode,
    input  logic [WORD_W-1:0]     ddr_opstore_write_mask,
    input  logic [WORD_W-1:0]     ddr_opstore_write_data,
    output logic [WORD_W-1:0]     ddr_opload_read_data,
    output logic [LINE_W-1:0]     ddr_pc_read_inst,
    output logic                  ddr_operation_done,
    output logic                  ddr_ready
);

    localparam int WAIT_W = wait_cnt_width(LATENCY);

    ddr_state_e                state;
    logic [WAIT_W-1:0]         wait_cnt;
    logic [BEAT_W-1:0]         beat_cnt;
    logic [ADDR_WIDTH-1:0]     idx_q;
    logic                      we_q;
    logic                      burst_q;
    logic [WORD_W-1:0]         mask_q;
    logic [WORD_W-1:0]         data_q;
    logic [LINE_W-WORD_W-1:0]  shadow_line;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_we;
    logic [WORD_W-1:0]         mem_rdata;
    logic                      last_beat;

    assign last_beat = !burst_q || (beat_cnt == BEAT_W'(BURST_BEATS - 1));
    assign mem_we    = (state == ST_ACCESS) && we_q;

    // The array read is one cycle deep, so the address runs one beat ahead:
    // WAIT prefetches beat 0 and ACCESS beat k requests beat k+1.
    always_comb begin
        mem_addr = idx_q;
        if ((state == ST_ACCESS) && burst_q) begin
            mem_addr = idx_q + ADDR_WIDTH'(beat_cnt) + ADDR_WIDTH'(1);
        end
    end

    ddr_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_mem (
        .clock        (clock),
        .addr         (mem_addr),
        .write_enable (mem_we),
        .write_mask   (mask_q),
        .write_data   (data_q),
        .read_data    (mem_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            ddr_ready            <= 1'b1;
            ddr_operation_done   <= 1'b0;
            ddr_opload_read_data <= '0;
            ddr_pc_read_inst     <= '0;
            wait_cnt             <= '0;
            beat_cnt             <= '0;
            idx_q                <= '0;
            we_q                 <= 1'b0;
            burst_q              <= 1'b0;
            mask_q               <= '0;
            data_q               <= '0;
            shadow_line          <= '0;
        end else begin
            ddr_operation_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ddr_chip_enable) begin
                        idx_q     <= ddr_index;
                        we_q      <= ddr_write_enable;
                        burst_q   <= ddr_burst_mode && !ddr_write_enable;
                        mask_q    <= ddr_opstore_write_mask;
                        data_q    <= ddr_opstore_write_data;
                        wait_cnt  <= WAIT_W'(LATENCY - 1);
                        beat_cnt  <= '0;
                        ddr_ready <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // Results land on the edge into DONE so data is valid alongside the pulse.
                    if (!we_q) begin
                        if (!burst_q) begin
                            ddr_opload_read_data <= mem_rdata;
                        end else if (last_beat) begin
                            ddr_pc_read_inst <= {mem_rdata, shadow_line};
                        end else begin
                            shadow_line[beat_cnt*WORD_W +: WORD_W] <= mem_rdata;
                        end
                    end
                    if (last_beat) begin
                        beat_cnt           <= '0;
                        ddr_operation_done <= 1'b1;
                        state              <= ST_DONE;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ddr_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_responder.sv
// Randomized scoreboard bench for ddr_responder against a word-array model.
module tb_ddr_responder;

    localparam int AW    = 19;
    localparam int LAT   = 4;
    localparam int DEPTH = 1 << AW;
    localparam int EXP_W = 32 + 64 + 512;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ddr_chip_enable = 1'b0;
    logic [AW-1:0] ddr_index = '0;
    logic          ddr_write_enable = 1'b0;
    logic          ddr_burst_mode = 1'b0;
    logic [63:0]   ddr_opstore_write_mask = '0;
    logic [63:0]   ddr_opstore_write_data = '0;
    logic [63:0]   ddr_opload_read_data;
    logic [511:0]  ddr_pc_read_inst;
    logic          ddr_operation_done;
    logic          ddr_ready;

    ddr_responder #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT),
        .INIT_FILE  ("")
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .ddr_chip_enable        (ddr_chip_enable),
        .ddr_index              (ddr_index),
        .ddr_write_enable       (ddr_write_enable),
        .ddr_burst_mode         (ddr_burst_mode),
        .ddr_opstore_write_mask (ddr_opstore_write_mask),
        .ddr_opstore_write_data (ddr_opstore_write_data),
        .ddr_opload_read_data   (ddr_opload_read_data),
        .ddr_pc_read_inst       (ddr_pc_read_inst),
        .ddr_operation_done     (ddr_operation_done),
        .ddr_ready              (ddr_ready)
    );

    // Clock / reset
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard state: expected {done_cycle, opload, pc_inst} per accepted op
    int          total = 0;
    int          bad = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [63:0]  model_mem [int];
    logic [63:0]  cur_word = '0;
    logic [511:0] cur_line = '0;
    int           exp_ready_cyc = -1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mem_rd(input int idx);
        int a;
        a = idx & (DEPTH - 1);
        return model_mem.exists(a) ? model_mem[a] : 64'h0;
    endfunction

    function automatic int pool_idx(input int r);
        return (r < 16) ? r : (DEPTH - 16 + (r - 16));
    endfunction

    function automatic int burst_start(input int r);
        return (r < 9) ? r : (DEPTH - 16 + (r - 9));
    endfunction

    // Driver tasks (called at a negedge, return at a negedge)
    task automatic wait_ready();
        int n = 0;
        while (ddr_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (ddr_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=%b want 1 within 200 cycles", ddr_ready);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (exp_ready_cyc >= 0) begin
            chk("ready_return_cycle", 512'(cyc), 512'(exp_ready_cyc));
            exp_ready_cyc = -1;
        end
    endtask

    task automatic issue(input bit we, input bit burst, input int idx,
                         input logic [63:0] mask, input logic [63:0] data,
                         input bit hold_ce, input bit commit);
        int t0;
        int done_at;
        int a;
        wait_ready();
        a = idx & (DEPTH - 1);
        ddr_chip_enable        = 1'b1;
        ddr_write_enable       = we;
        ddr_burst_mode         = burst;
        ddr_index              = AW'(a);
        ddr_opstore_write_mask = mask;
        ddr_opstore_write_data = data;
        t0 = cyc;
        if (commit) begin
            if (we) begin
                model_mem[a] = (mem_rd(a) & ~mask) | (data & mask);
            end else if (burst) begin
                for (int k = 0; k < 8; k++) cur_line[64*k +: 64] = mem_rd(a + k);
            end else begin
                cur_word = mem_rd(a);
            end
            done_at = t0 + LAT + ((!we && burst) ? 9 : 2);
            exp_q.push_back({32'(done_at), cur_word, cur_line});
            exp_ready_cyc = done_at + 1;
        end
        @(negedge clock);
        if (!hold_ce) ddr_chip_enable = 1'b0;
        chk("ready_drop", 512'(ddr_ready), 512'(0));
    endtask

    // Monitor: pops one expectation per done pulse
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clock);
            if (!reset && ddr_operation_done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 512'(ddr_operation_done), 512'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("done_cycle", 512'(cyc), 512'(e[607:576]));
                    chk("opload_read_data", 512'(ddr_opload_read_data), 512'(e[575:512]));
                    chk("pc_read_inst", ddr_pc_read_inst, e[511:0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int op;
        bit hold;
        int n;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("reset_ready_during", 512'(ddr_ready), 512'(1));
        reset = 1'b0;
        @(negedge clock);
        chk("reset_ready", 512'(ddr_ready), 512'(1));
        chk("reset_done", 512'(ddr_operation_done), 512'(0));
        chk("reset_opload", 512'(ddr_opload_read_data), 512'(0));
        chk("reset_pc_inst", ddr_pc_read_inst, 512'(0));

        // Full-mask store, read back, partial-mask overwrite, zero-mask no-op
        issue(1'b1, 1'b0, 'h10, '1, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 'h10, '0, '0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 'h10, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 'h10, '0, '0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        issue(1'b0, 1'b0, 'h10, '0, '0, 1'b0, 1'b1);

        // Wrapping burst over mem[i]=i at the top of the array
        for (int k = 0; k < 8; k++) begin
            issue(1'b1, 1'b0, (32'h7FFFC + k) & (DEPTH - 1), '1,
                  64'((32'h7FFFC + k) & (DEPTH - 1)), 1'b0, 1'b1);
        end
        issue(1'b0, 1'b1, 'h7FFFC, '0, '0, 1'b0, 1'b1);

        // chip_enable held through a busy burst, then back-to-back read
        issue(1'b0, 1'b1, 'h7FFFE, '0, '0, 1'b1, 1'b1);
        issue(1'b0, 1'b0, 'h7FFFF, '0, '0, 1'b0, 1'b1);

        // Reset during WAIT of a store must drop it
        issue(1'b1, 1'b0, 'h20, '1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 'h20, '1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("midop_reset_ready", 512'(ddr_ready), 512'(1));
        reset = 1'b0;
        exp_ready_cyc = -1;
        cur_word = '0;
        cur_line = '0;
        repeat (LAT + 12) @(negedge clock);
        chk("midop_ready", 512'(ddr_ready), 512'(1));
        chk("midop_opload_cleared", 512'(ddr_opload_read_data), 512'(0));
        chk("midop_pc_inst_cleared", ddr_pc_read_inst, 512'(0));
        issue(1'b0, 1'b0, 'h20, '0, '0, 1'b0, 1'b1);

        // Randomized traffic over a pool spanning both ends of the array
        for (int i = 0; i < 32; i++) begin
            issue(1'b1, 1'b0, pool_idx(i), '1, {$urandom, $urandom}, 1'b0, 1'b1);
        end
        for (int i = 0; i < 60; i++) begin
            op   = $urandom_range(0, 4);
            hold = ($urandom_range(0, 3) == 0);
            case (op)
                0: issue(1'b1, 1'b0, pool_idx($urandom_range(0, 31)),
                         {$urandom, $urandom}, {$urandom, $urandom}, hold, 1'b1);
                1: issue(1'b1, 1'b1, pool_idx($urandom_range(0, 31)),
                         '1, {$urandom, $urandom}, hold, 1'b1);
                2, 3: issue(1'b0, 1'b0, pool_idx($urandom_range(0, 31)),
                            '0, '0, hold, 1'b1);
                default: issue(1'b0, 1'b1, burst_start($urandom_range(0, 24)),
                               '0, '0, hold, 1'b1);
            endcase
        end
        ddr_chip_enable = 1'b0;

        // Drain
        wait_ready();
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", 512'(exp_q.size()), 512'(0));
        repeat (5) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
